kernel_stream_packer: RTL and testbench
=======================================

// Module: kernel_stream_packer
// PURPOSE
//  Sink end of a kernel output stream. Accepts STREAMW-bit words on the ivalid/iready handshake that a kernelTop drives with ovalid/oready.
//  Packs VECT consecutive words into one VECT*STREAMW word for the memory-write side. Tracks a job of NELEM words armed by start.
//  Flags the last packed word and signals done.
// PARAMETERS
//  STREAMW  32  width of one kernel stream word
//  VECT     8   lanes per packed output word (power of 2, >=2)
//  NELEM    1024 words per job (>=1; need not be a multiple of VECT)
// PORTS
//  clk      in   1                clock, all logic on posedge
//  rst      in   1                synchronous, active-high reset
//  start    in   1                1-cycle pulse; arms a job (ignored unless IDLE)
//  ivalid   in   1                kernel output word valid (from kernel ovalid)
//  iready   out  1                packer accepts word (to kernel oready)
//  in1_s0   in   STREAMW          kernel output word
//  ovalid   out  1                packed word valid
//  oready   in   1                downstream accepts packed word
//  out1_s0  out  VECT*STREAMW     packed word, lane 0 = first word in bits [STREAMW-1:0]
//  okeep    out  VECT             per-lane valid mask for out1_s0
//  olast    out  1                marks final packed word of job
//  done     out  1                high in DONE state
//  count    out  $clog2(NELEM+1)  words accepted this job
// BEHAVIOUR
//  Reset: state=IDLE; iready, ovalid, olast, done=0; okeep, out1_s0, count, lane index=0. Reset mid-job discards all data and returns to IDLE.
//  States: IDLE -start-> FILL; FILL -last word accepted-> DRAIN; DRAIN -final packed word taken (ovalid&oready&olast)-> DONE; DONE -start-> FILL (clears count, done).
//  Input transfer = ivalid&iready. Word goes into lane[lane_idx]; lane_idx and count increment.
//  A packed word completes on the transfer that fills lane VECT-1 or carries count==NELEM-1. It moves to the output register in the same clock edge.
//  Unused upper lanes of a partial final word are zero; okeep reflects the filled lanes only.
//  Output register: ovalid rises the cycle after the completing transfer (latency 1). It holds out1_s0/okeep/olast stable until oready.
//  iready = (state==FILL) & !(completing_slot & ovalid & !oready). The packer stalls only when a word would complete while the output register is held.
//    A simultaneous oready frees the register in the same cycle, so no bubble occurs.
//  Sustained throughput: 1 input word/cycle with oready tied high.
//  lane_idx wraps VECT-1 -> 0 on completion. count saturates at NELEM; words after the NELEM-th are not accepted (iready=0 outside FILL).
//  start while FILL/DRAIN: ignored. start in DONE and start pulse: job restarts the next cycle.
//  ivalid while IDLE: not accepted, no state change.
// CONFIGURATION
//  STREAM_CHECKSUM_EN defined: adds output port csum [STREAMW-1:0].
//    csum is the running XOR of every accepted in1_s0 word. It is cleared by rst and start and is valid when done=1.
//  Undefined: port absent, no checksum logic; all other behaviour identical.
// STRUCTURE
//  Shared package kernel_stream_pkg: state enum {IDLE,FILL,DRAIN,DONE}, lane-index width function, default STREAMW/VECT constants.
//  One sub-module: stream_pack_lanes. It holds the lane shift/write, lane_idx and the okeep generator.
//  The FSM, output register and counters stay in the top.
// TESTING
//  1 STREAMW=32,VECT=8,NELEM=16, oready=1, words 0..15 back-to-back -> two packed words 0x7..0/0xF..8 lanes, okeep=8'hFF, olast on 2nd, done 1 cycle after.
//  2 NELEM=11 -> 2nd packed word lanes 8..10, upper 5 lanes zero, okeep=8'h07, olast=1.
//  3 oready low 20 cycles, continuous ivalid -> iready drops exactly on the 16th word. No word is lost or duplicated.
//    out1_s0 stays stable while held.
//  4 rst pulse after 5 accepted words -> next cycle all outputs at reset values. A new start plus 16 words gives a clean result identical to test 1.
//  5 ivalid before start and start during FILL -> no words accepted in IDLE, count unaffected by the 2nd start.
//  6 STREAM_CHECKSUM_EN, words 0x1,0x2,0x4 (NELEM=3) -> csum=0x7 with done=1. Without the macro the design elaborates without csum.

Source files
------------

// File: rtl/kernel_stream_pkg.sv
// Shared types for the kernel stream packer: FSM state, lane-index width helper, default sizes.
// Pure declarations, so there is no latency or backpressure here.
package kernel_stream_pkg;

  localparam int DEF_STREAMW = 32;
  localparam int DEF_VECT    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int lane_idx_w(input int vect);
    return (vect > 1) ? $clog2(vect) : 1;
  endfunction

endpackage

// File: rtl/stream_pack_lanes.sv
// Lane accumulator: writes each accepted word into lane[lane_idx]; the packed word and keep mask are combinational.
// Completion is flagged in the same cycle as the write. Applies no backpressure (the caller gates wr_en).
module stream_pack_lanes
  import kernel_stream_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int VECT    = DEF_VECT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [STREAMW-1:0]      wr_dat,
  input  logic                    last_slot,
  output logic                    slot_completes,
  output logic                    complete,
  output logic [VECT*STREAMW-1:0] packed_dat,
  output logic [VECT-1:0]         packed_keep
);

  localparam int LW = lane_idx_w(VECT);

  logic [VECT*STREAMW-1:0] lane_buf_q, lane_buf_d;
  logic [LW-1:0]           lane_idx_q, lane_idx_d;

  assign slot_completes = (lane_idx_q == LW'(VECT-1)) | last_slot;
  assign complete       = wr_en & slot_completes;

  // Merge the incoming word into the current lane so a completing word can leave in the same edge.
  always_comb begin
    packed_dat  = lane_buf_q;
    packed_keep = '0;
    for (int i = 0; i < VECT; i++) begin
      if (i == int'(lane_idx_q)) packed_dat[i*STREAMW +: STREAMW] = wr_dat;
      if (i <= int'(lane_idx_q)) packed_keep[i] = 1'b1;
    end
  end

  // The buffer is zeroed on completion, which keeps the unused lanes of a partial final word at zero.
  always_comb begin
    lane_buf_d = lane_buf_q;
    lane_idx_d = lane_idx_q;
    if (clr) begin
      lane_buf_d = '0;
      lane_idx_d = '0;
    end else if (wr_en) begin
      if (complete) begin
        lane_buf_d = '0;
        lane_idx_d = '0;
      end else begin
        lane_buf_d = packed_dat;
        lane_idx_d = lane_idx_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_buf_q <= '0;
      lane_idx_q <= '0;
    end else begin
      lane_buf_q <= lane_buf_d;
      lane_idx_q <= lane_idx_d;
    end
  end

endmodule

// File: rtl/kernel_stream_packer.sv
// Packs VECT kernel stream words per output beat for a job of NELEM words; STREAM_CHECKSUM_EN adds an XOR checksum port csum.
// ovalid follows the completing transfer by 1 cycle; iready drops only when a completing word meets a held output beat.
module kernel_stream_packer
  import kernel_stream_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int VECT    = DEF_VECT,
  parameter int NELEM   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       ivalid,
  output logic                       iready,
  input  logic [STREAMW-1:0]         in1_s0,
  output logic                       ovalid,
  input  logic                       oready,
  output logic [VECT*STREAMW-1:0]    out1_s0,
  output logic [VECT-1:0]            okeep,
  output logic                       olast,
  output logic                       done,
  output logic [$clog2(NELEM+1)-1:0] count
`ifdef STREAM_CHECKSUM_EN
  , output logic [STREAMW-1:0]       csum
`endif
);

  localparam int CW = $clog2(NELEM+1);

  state_e state_q, state_d;

  logic [CW-1:0]           count_q, count_d;
  logic                    ovalid_q, ovalid_d;
  logic [VECT*STREAMW-1:0] out_dat_q, out_dat_d;
  logic [VECT-1:0]         okeep_q, okeep_d;
  logic                    olast_q, olast_d;

  logic                    start_ok;
  logic                    in_xfer;
  logic                    out_take;
  logic                    last_slot;
  logic                    slot_completes;
  logic                    lane_complete;
  logic [VECT*STREAMW-1:0] packed_dat;
  logic [VECT-1:0]         packed_keep;

  assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE));
  assign in_xfer   = ivalid & iready;
  assign out_take  = ovalid_q & oready;
  assign last_slot = (count_q == CW'(NELEM-1));

  stream_pack_lanes #(
    .STREAMW (STREAMW),
    .VECT    (VECT)
  ) u_lanes (
    .clk            (clk),
    .rst            (rst),
    .clr            (start_ok),
    .wr_en          (in_xfer),
    .wr_dat         (in1_s0),
    .last_slot      (last_slot),
    .slot_completes (slot_completes),
    .complete       (lane_complete),
    .packed_dat     (packed_dat),
    .packed_keep    (packed_keep)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (in_xfer && last_slot) state_d = DRAIN;
      DRAIN:   if (out_take && olast_q) state_d = DONE;
      DONE:    if (start) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle oready frees the output register, so the completing word still goes through.
  always_comb begin
    iready = (state_q == FILL) & !(slot_completes & ovalid_q & !oready);
    done   = (state_q == DONE);
  end

  always_comb begin
    count_d   = count_q;
    ovalid_d  = ovalid_q;
    out_dat_d = out_dat_q;
    okeep_d   = okeep_q;
    olast_d   = olast_q;
    if (start_ok)     count_d = '0;
    else if (in_xfer) count_d = count_q + CW'(1);
    if (out_take) ovalid_d = 1'b0;
    if (lane_complete) begin
      ovalid_d  = 1'b1;
      out_dat_d = packed_dat;
      okeep_d   = packed_keep;
      olast_d   = last_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      ovalid_q  <= 1'b0;
      out_dat_q <= '0;
      okeep_q   <= '0;
      olast_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      ovalid_q  <= ovalid_d;
      out_dat_q <= out_dat_d;
      okeep_q   <= okeep_d;
      olast_q   <= olast_d;
    end
  end

  assign count   = count_q;
  assign ovalid  = ovalid_q;
  assign out1_s0 = out_dat_q;
  assign okeep   = okeep_q;
  assign olast   = olast_q;

`ifdef STREAM_CHECKSUM_EN
  logic [STREAMW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_ok)     csum_d = '0;
    else if (in_xfer) csum_d = csum_q ^ in1_s0;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_kernel_stream_packer.sv
// Bench for kernel_stream_packer: three instances (NELEM 16/11/3) sharing the input stream, observed through a selector.
module tb_kernel_stream_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid = 1'b0;
  logic        oready = 1'b1;
  logic [31:0] in_dat = '0;
  logic        st16 = 1'b0, st11 = 1'b0, st3 = 1'b0;
  int          sel = 0;

  logic         ir16, ir11, ir3, ov16, ov11, ov3, la16, la11, la3, dn16, dn11, dn3;
  logic [255:0] d16, d11, d3;
  logic [7:0]   k16, k11, k3;
  logic [4:0]   c16;
  logic [3:0]   c11;
  logic [1:0]   c3;
`ifdef STREAM_CHECKSUM_EN
  logic [31:0]  s16, s11, s3, m_csum;
`endif

  logic         m_iready, m_ovalid, m_last, m_done;
  logic [255:0] m_dat;
  logic [7:0]   m_keep;
  int           m_count;

  always #5 clk = ~clk;

  kernel_stream_packer #(.STREAMW(32), .VECT(8), .NELEM(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .ivalid(ivalid), .iready(ir16), .in1_s0(in_dat),
    .ovalid(ov16), .oready(oready), .out1_s0(d16), .okeep(k16), .olast(la16), .done(dn16),
    .count(c16)
`ifdef STREAM_CHECKSUM_EN
    , .csum(s16)
`endif
  );

  kernel_stream_packer #(.STREAMW(32), .VECT(8), .NELEM(11)) u11 (
    .clk(clk), .rst(rst), .start(st11), .ivalid(ivalid), .iready(ir11), .in1_s0(in_dat),
    .ovalid(ov11), .oready(oready), .out1_s0(d11), .okeep(k11), .olast(la11), .done(dn11),
    .count(c11)
`ifdef STREAM_CHECKSUM_EN
    , .csum(s11)
`endif
  );

  kernel_stream_packer #(.STREAMW(32), .VECT(8), .NELEM(3)) u3 (
    .clk(clk), .rst(rst), .start(st3), .ivalid(ivalid), .iready(ir3), .in1_s0(in_dat),
    .ovalid(ov3), .oready(oready), .out1_s0(d3), .okeep(k3), .olast(la3), .done(dn3),
    .count(c3)
`ifdef STREAM_CHECKSUM_EN
    , .csum(s3)
`endif
  );

  always_comb begin
    case (sel)
      1: begin
        m_iready = ir11; m_ovalid = ov11; m_last = la11; m_done = dn11;
        m_dat = d11; m_keep = k11; m_count = 32'(c11);
      end
      2: begin
        m_iready = ir3; m_ovalid = ov3; m_last = la3; m_done = dn3;
        m_dat = d3; m_keep = k3; m_count = 32'(c3);
      end
      default: begin
        m_iready = ir16; m_ovalid = ov16; m_last = la16; m_done = dn16;
        m_dat = d16; m_keep = k16; m_count = 32'(c16);
      end
    endcase
`ifdef STREAM_CHECKSUM_EN
    case (sel)
      1:       m_csum = s11;
      2:       m_csum = s3;
      default: m_csum = s16;
    endcase
`endif
  end

  typedef struct {
    logic [255:0] dat;
    logic [7:0]   keep;
    logic         last;
  } beat_t;

  typedef struct {
    int          sel;
    int          nwords;
    logic [31:0] base;
    bit          shift;
    int          nbeats;
    logic [7:0]  keep_last;
    logic [31:0] csum;
  } job_t;

  beat_t beats[$];
  job_t  jobs[4];
  int    n_vec = 0;
  int    n_bad = 0;

  // Output beats are captured at the negedge preceding the edge where they are taken.
  always @(negedge clk) begin
    if (!rst && m_ovalid && oready) beats.push_back('{m_dat, m_keep, m_last});
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wgen(input logic [31:0] base, input bit shift, input int i);
    return shift ? (base << i) : (base + 32'(i));
  endfunction

  function automatic logic [255:0] pack_exp(input logic [31:0] base, input bit shift,
                                            input int first, input int nl);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < nl; k++) r[k*32 +: 32] = wgen(base, shift, first + k);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; ivalid = 1'b0; st16 = 1'b0; st11 = 1'b0; st3 = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    case (sel)
      1:       st11 = 1'b1;
      2:       st3  = 1'b1;
      default: st16 = 1'b1;
    endcase
    tick;
    st16 = 1'b0; st11 = 1'b0; st3 = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    ivalid = 1'b1;
    in_dat = w;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (m_iready) ok = 1'b1;
      tick;
    end
    chk("push_accepted", 256'(ok), 256'(1));
  endtask

  task automatic wait_done;
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (m_done) ok = 1'b1;
    end
    chk("done_reached", 256'(ok), 256'(1));
    tick;
  endtask

  task automatic run_job(input int j);
    job_t jb;
    int   nl;
    jb  = jobs[j];
    sel = jb.sel;
    oready = 1'b1;
    beats.delete();
    pulse_start;
    for (int i = 0; i < jb.nwords; i++) push(wgen(jb.base, jb.shift, i));
    ivalid = 1'b0;
    @(negedge clk);
    chk($sformatf("job%0d_final_ovalid", j), 256'(m_ovalid), 256'(1));
    chk($sformatf("job%0d_final_olast", j), 256'(m_last), 256'(1));
    chk($sformatf("job%0d_done_early", j), 256'(m_done), 256'(0));
    @(negedge clk);
    chk($sformatf("job%0d_done", j), 256'(m_done), 256'(1));
    chk($sformatf("job%0d_count", j), 256'(m_count), 256'(jb.nwords));
`ifdef STREAM_CHECKSUM_EN
    chk($sformatf("job%0d_csum", j), 256'(m_csum), 256'(jb.csum));
`endif
    chk($sformatf("job%0d_nbeats", j), 256'(beats.size()), 256'(jb.nbeats));
    for (int b = 0; b < jb.nbeats && b < beats.size(); b++) begin
      nl = (b == jb.nbeats - 1) ? (jb.nwords - b*8) : 8;
      chk($sformatf("job%0d_b%0d_dat", j, b), beats[b].dat, pack_exp(jb.base, jb.shift, b*8, nl));
      chk($sformatf("job%0d_b%0d_keep", j, b), 256'(beats[b].keep),
          256'((b == jb.nbeats - 1) ? jb.keep_last : 8'hFF));
      chk($sformatf("job%0d_b%0d_last", j, b), 256'(beats[b].last), 256'(b == jb.nbeats - 1));
    end
    tick;
  endtask

  initial begin
    logic [255:0] held;
    bit           have_held, stable;
    int           w, first_stall;

    jobs[0] = '{0, 16, 32'h0,   1'b0, 2, 8'hFF, 32'h0};
    jobs[1] = '{1, 11, 32'h0,   1'b0, 2, 8'h07, 32'hB};
    jobs[2] = '{0, 16, 32'h100, 1'b0, 2, 8'hFF, 32'h0};
    jobs[3] = '{2, 3,  32'h1,   1'b1, 1, 8'h07, 32'h7};

    do_reset;
    sel = 0;
    chk("rst_iready", 256'(m_iready), 256'(0));
    chk("rst_ovalid", 256'(m_ovalid), 256'(0));
    chk("rst_olast", 256'(m_last), 256'(0));
    chk("rst_done", 256'(m_done), 256'(0));
    chk("rst_keep", 256'(m_keep), 256'(0));
    chk("rst_dat", m_dat, 256'(0));
    chk("rst_count", 256'(m_count), 256'(0));

    for (int j = 0; j < 4; j++) run_job(j);

    // Output held low: the 16th word must be the first one refused.
    sel = 0; beats.delete();
    pulse_start;
    oready = 1'b0; ivalid = 1'b1;
    w = 0; first_stall = -1; have_held = 1'b0; stable = 1'b1; held = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_dat = 32'(w);
      @(negedge clk);
      if (m_ovalid) begin
        if (!have_held) begin held = m_dat; have_held = 1'b1; end
        else if (m_dat !== held) stable = 1'b0;
      end
      if (m_iready) w++;
      else if (first_stall < 0) first_stall = w;
      tick;
    end
    chk("stall_accepted", 256'(w), 256'(15));
    chk("stall_first_refused", 256'(first_stall), 256'(15));
    chk("stall_iready", 256'(m_iready), 256'(0));
    chk("stall_count", 256'(m_count), 256'(15));
    chk("stall_dat_stable", 256'(stable), 256'(1));
    chk("stall_held_dat", held, pack_exp(32'h0, 1'b0, 0, 8));
    oready = 1'b1;
    push(32'd15);
    ivalid = 1'b0;
    wait_done;
    chk("stall_nbeats", 256'(beats.size()), 256'(2));
    if (beats.size() == 2) begin
      chk("stall_b0_dat", beats[0].dat, pack_exp(32'h0, 1'b0, 0, 8));
      chk("stall_b1_dat", beats[1].dat, pack_exp(32'h0, 1'b0, 8, 8));
      chk("stall_b1_last", 256'(beats[1].last), 256'(1));
    end

    // Reset in the middle of a job.
    sel = 0;
    pulse_start;
    for (int i = 0; i < 5; i++) push(32'(i + 32'h50));
    ivalid = 1'b0;
    chk("midrst_pre_count", 256'(m_count), 256'(5));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_iready", 256'(m_iready), 256'(0));
    chk("midrst_ovalid", 256'(m_ovalid), 256'(0));
    chk("midrst_dat", m_dat, 256'(0));
    chk("midrst_keep", 256'(m_keep), 256'(0));
    chk("midrst_count", 256'(m_count), 256'(0));
    chk("midrst_done", 256'(m_done), 256'(0));
    run_job(0);

    // Words offered in IDLE are ignored; a second start during FILL changes nothing.
    do_reset;
    sel = 0; beats.delete();
    ivalid = 1'b1; in_dat = 32'hAA;
    repeat (5) tick;
    chk("idle_count", 256'(m_count), 256'(0));
    chk("idle_iready", 256'(m_iready), 256'(0));
    ivalid = 1'b0;
    pulse_start;
    for (int i = 0; i < 3; i++) push(32'(i));
    ivalid = 1'b0;
    pulse_start;
    chk("restart_fill_count", 256'(m_count), 256'(3));
    for (int i = 3; i < 16; i++) push(32'(i));
    ivalid = 1'b0;
    wait_done;
    chk("restart_final_count", 256'(m_count), 256'(16));
    chk("restart_nbeats", 256'(beats.size()), 256'(2));
    if (beats.size() == 2) begin
      chk("restart_b0_dat", beats[0].dat, pack_exp(32'h0, 1'b0, 0, 8));
      chk("restart_b1_dat", beats[1].dat, pack_exp(32'h0, 1'b0, 8, 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
